crtc_config_sequencer: RTL and testbench

CRTC_CONFIG_SEQUENCER -- requirements
Module: crtc_config_sequencer

---
 rtl/crtc_config_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_crtc_config_sequencer.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/crtc_config_sequencer.sv
// CRTC configuration sequencer: streams a 16-register mode table to the CRTC,
// then restores the CPU's last address write. Between loads it passes CPU accesses through.
module crtc_config_sequencer (
  input  logic       CLOCK,
  input  logic       nRESET,
  input  logic       CLKEN,
  input  logic       MODE_REQ,
  input  logic       MODE_SEL,
  input  logic       CPU_REQ,
  input  logic       CPU_RS,
  input  logic       CPU_R_nW,
  input  logic [7:0] CPU_DI,
  output logic       CPU_ACK,
  output logic [7:0] CPU_DO,
  output logic       CRTC_ENABLE,
  output logic       CRTC_nCS,
  output logic       CRTC_R_nW,
  output logic       CRTC_RS,
  output logic [7:0] CRTC_DI,
  input  logic [7:0] CRTC_DO,
  output logic       BUSY,
  output logic       DONE
);
  typedef enum logic [2:0] {ST_IDLE, ST_SEQ_ADDR, ST_SEQ_DATA, ST_RESTORE, ST_DONE} state_t;

  state_t      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic        sel_q, sel_d;
  logic [4:0]  shadow_q, shadow_d;
  logic        pend_q, pend_d;
  logic        boot_q, boot_d;
  logic [7:0]  cpu_do_q, cpu_do_d;
  logic        cpu_ack_q, cpu_ack_d;
  logic        cpu_rd_q, cpu_rd_d;
  logic        en_q, en_d;
  logic        ncs_q, ncs_d;
  logic        rnw_q, rnw_d;
  logic        rs_q, rs_d;
  logic [7:0]  di_q, di_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        start;

  function automatic logic [7:0] tbl(input logic sel, input logic [3:0] i);
    logic [7:0] v;
    case (i)
      4'd0:    v = sel ? 8'h7E : 8'h3F;
      4'd1:    v = sel ? 8'h50 : 8'h28;
      4'd2:    v = sel ? 8'h5C : 8'h2E;
      4'd3:    v = sel ? 8'h3A : 8'h35;
      4'd4:    v = 8'h1E;
      4'd6:    v = 8'h19;
      4'd7:    v = 8'h1B;
      4'd9:    v = 8'h07;
      4'd10:   v = 8'h67;
      4'd11:   v = 8'h07;
      default: v = 8'h00;
    endcase
    return v;
  endfunction

  // boot_q forces one table-0 load after every reset release
  assign start = MODE_REQ | pend_q | boot_q;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    sel_d     = sel_q;
    shadow_d  = shadow_q;
    pend_d    = pend_q;
    boot_d    = boot_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    cpu_ack_d = 1'b0;
    cpu_rd_d  = 1'b0;
    cpu_do_d  = cpu_rd_q ? CRTC_DO : cpu_do_q;
    en_d      = 1'b0;
    rnw_d     = 1'b1;
    rs_d      = 1'b0;
    di_d      = 8'h00;
    if (busy_q && CLKEN && MODE_REQ) pend_d = 1'b1;
    case (state_q)
      ST_IDLE: if (CLKEN) begin
        if (start) begin
          state_d = ST_SEQ_ADDR;
          idx_d   = 4'd0;
          sel_d   = boot_q ? 1'b0 : MODE_SEL;
          boot_d  = 1'b0;
          pend_d  = 1'b0;
          busy_d  = 1'b1;
        end else if (CPU_REQ) begin
          en_d      = 1'b1;
          rnw_d     = CPU_R_nW;
          rs_d      = CPU_RS;
          di_d      = CPU_DI;
          cpu_ack_d = 1'b1;
          cpu_rd_d  = CPU_R_nW;
          if (!CPU_R_nW && !CPU_RS) shadow_d = CPU_DI[4:0];
        end
      end
      ST_SEQ_ADDR: if (CLKEN) begin
        en_d    = 1'b1;
        rnw_d   = 1'b0;
        di_d    = {4'h0, idx_q};
        state_d = ST_SEQ_DATA;
      end
      ST_SEQ_DATA: if (CLKEN) begin
        en_d  = 1'b1;
        rnw_d = 1'b0;
        rs_d  = 1'b1;
        di_d  = tbl(sel_q, idx_q);
        if (idx_q == 4'd15) state_d = ST_RESTORE;
        else begin
          idx_d   = idx_q + 4'd1;
          state_d = ST_SEQ_ADDR;
        end
      end
      ST_RESTORE: if (CLKEN) begin
        en_d    = 1'b1;
        rnw_d   = 1'b0;
        di_d    = {3'b000, shadow_q};
        state_d = ST_DONE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        idx_d   = 4'd0;
      end
      default: state_d = ST_IDLE;
    endcase
    ncs_d = ~en_d;
  end

  always_ff @(posedge CLOCK or negedge nRESET) begin
    if (!nRESET) begin
      state_q   <= ST_IDLE;
      idx_q     <= 4'd0;
      sel_q     <= 1'b0;
      shadow_q  <= 5'd0;
      pend_q    <= 1'b0;
      boot_q    <= 1'b1;
      cpu_do_q  <= 8'h00;
      cpu_ack_q <= 1'b0;
      cpu_rd_q  <= 1'b0;
      en_q      <= 1'b0;
      ncs_q     <= 1'b1;
      rnw_q     <= 1'b1;
      rs_q      <= 1'b0;
      di_q      <= 8'h00;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      sel_q     <= sel_d;
      shadow_q  <= shadow_d;
      pend_q    <= pend_d;
      boot_q    <= boot_d;
      cpu_do_q  <= cpu_do_d;
      cpu_ack_q <= cpu_ack_d;
      cpu_rd_q  <= cpu_rd_d;
      en_q      <= en_d;
      ncs_q     <= ncs_d;
      rnw_q     <= rnw_d;
      rs_q      <= rs_d;
      di_q      <= di_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign CPU_ACK     = cpu_ack_q;
  assign CPU_DO      = cpu_do_q;
  assign CRTC_ENABLE = en_q;
  assign CRTC_nCS    = ncs_q;
  assign CRTC_R_nW   = rnw_q;
  assign CRTC_RS     = rs_q;
  assign CRTC_DI     = di_q;
  assign BUSY        = busy_q;
  assign DONE        = done_q;
endmodule

// File: tb/tb_crtc_config_sequencer.sv
// Directed bench for crtc_config_sequencer: strobes are logged shortly after each
// rising edge; scenario tasks compare the log and pins against hand-derived values.
module tb_crtc_config_sequencer;
  logic CLOCK = 1'b0, nRESET = 1'b0, CLKEN = 1'b0;
  logic MODE_REQ = 1'b0, MODE_SEL = 1'b0;
  logic CPU_REQ = 1'b0, CPU_RS = 1'b0, CPU_R_nW = 1'b1;
  logic [7:0] CPU_DI = 8'h00, CRTC_DO = 8'h00;
  logic CPU_ACK, CRTC_ENABLE, CRTC_nCS, CRTC_R_nW, CRTC_RS, BUSY, DONE;
  logic [7:0] CPU_DO, CRTC_DI;

  crtc_config_sequencer dut (
    .CLOCK(CLOCK), .nRESET(nRESET), .CLKEN(CLKEN), .MODE_REQ(MODE_REQ), .MODE_SEL(MODE_SEL),
    .CPU_REQ(CPU_REQ), .CPU_RS(CPU_RS), .CPU_R_nW(CPU_R_nW), .CPU_DI(CPU_DI),
    .CPU_ACK(CPU_ACK), .CPU_DO(CPU_DO), .CRTC_ENABLE(CRTC_ENABLE), .CRTC_nCS(CRTC_nCS),
    .CRTC_R_nW(CRTC_R_nW), .CRTC_RS(CRTC_RS), .CRTC_DI(CRTC_DI), .CRTC_DO(CRTC_DO),
    .BUSY(BUSY), .DONE(DONE));

  always #5 CLOCK = ~CLOCK;

  typedef struct { logic [9:0] bus; int cyc; } strobe_t;  // bus = {R_nW, RS, DI}
  strobe_t log_q[$];
  int cyc = 0, busy_cnt = 0, done_cnt = 0, ack_cnt = 0, done_cyc = 0, ack_cyc = 0;
  int clken_mode = 0;  // 0 off, 1 every cycle, 4 every 4th cycle
  int n_cmp = 0, n_bad = 0;
  logic [7:0] tbl0 [16] = '{8'h3F,8'h28,8'h2E,8'h35,8'h1E,8'h00,8'h19,8'h1B,
                            8'h00,8'h07,8'h67,8'h07,8'h00,8'h00,8'h00,8'h00};

  always begin
    @(posedge CLOCK); #2;
    cyc++;
    if (CRTC_ENABLE) log_q.push_back('{{CRTC_R_nW, CRTC_RS, CRTC_DI}, cyc});
    if (BUSY) busy_cnt++;
    if (DONE) begin done_cnt++; done_cyc = cyc; end
    if (CPU_ACK) begin ack_cnt++; ack_cyc = cyc; end
  end

  always @(negedge CLOCK)
    CLKEN = (clken_mode == 1) || (clken_mode == 4 && (cyc % 4) == 0);

  task automatic clear_log();
    log_q.delete(); busy_cnt = 0; done_cnt = 0; ack_cnt = 0;
  endtask

  task automatic wait_busy(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin @(negedge CLOCK); ok = BUSY; end
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin @(negedge CLOCK); ok = DONE; end
  endtask

  task automatic wait_ack(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin @(negedge CLOCK); ok = CPU_ACK; end
  endtask

  task automatic start_load(input logic sel);
    bit ok;
    MODE_SEL = sel; MODE_REQ = 1'b1;
    wait_busy(20, ok);
    MODE_REQ = 1'b0;
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL start_load: BUSY never rose"); end
  endtask

  task automatic test_reset();
    nRESET = 1'b0; clken_mode = 0;
    repeat (3) @(negedge CLOCK);
    n_cmp++;
    if ({CRTC_ENABLE, CRTC_nCS, CRTC_R_nW, CRTC_RS, CRTC_DI} !== {4'b0110, 8'h00}) begin
      n_bad++; $display("FAIL reset_bus: got %b/%h expected 0110/00",
                        {CRTC_ENABLE, CRTC_nCS, CRTC_R_nW, CRTC_RS}, CRTC_DI);
    end
    n_cmp++;
    if ({BUSY, DONE, CPU_ACK, CPU_DO} !== 11'h000) begin
      n_bad++; $display("FAIL reset_status: got %b %h expected 000 00", {BUSY, DONE, CPU_ACK}, CPU_DO);
    end
  endtask

  task automatic test_boot_load();
    bit ok;
    clear_log(); clken_mode = 1;
    @(negedge CLOCK); nRESET = 1'b1;
    wait_done(60, ok);
    repeat (3) @(negedge CLOCK);
    n_cmp++;
    if (!ok || log_q.size() != 33) begin
      n_bad++; $display("FAIL boot_count: got %0d strobes (done=%0b) expected 33", log_q.size(), ok);
    end else begin
      for (int i = 0; i < 16; i++) begin
        n_cmp++;
        if (log_q[2*i].bus !== {2'b00, 8'(i)}) begin
          n_bad++; $display("FAIL boot_addr%0d: got %h expected %h", i, log_q[2*i].bus, {2'b00, 8'(i)});
        end
        n_cmp++;
        if (log_q[2*i+1].bus !== {2'b01, tbl0[i]}) begin
          n_bad++; $display("FAIL boot_data%0d: got %h expected %h", i, log_q[2*i+1].bus, {2'b01, tbl0[i]});
        end
      end
      n_cmp++;
      if (log_q[32].bus !== 10'h000) begin
        n_bad++; $display("FAIL boot_restore: got %h expected 000", log_q[32].bus);
      end
      n_cmp++;
      if (log_q[32].cyc - log_q[0].cyc != 32) begin
        n_bad++; $display("FAIL boot_contig: got span %0d expected 32", log_q[32].cyc - log_q[0].cyc);
      end
    end
    n_cmp++;
    if (busy_cnt != 33 || done_cnt != 1) begin
      n_bad++; $display("FAIL boot_busy_done: got busy=%0d done=%0d expected 33 1", busy_cnt, done_cnt);
    end
  endtask

  task automatic test_mode1_sparse();
    bit ok;
    int bad_gap;
    logic [7:0] exp_d [4] = '{8'h7E, 8'h50, 8'h5C, 8'h3A};
    clear_log(); clken_mode = 4;
    start_load(1'b1);
    MODE_SEL = 1'b0;  // must not affect the load in flight
    wait_done(200, ok);
    repeat (6) @(negedge CLOCK);
    n_cmp++;
    if (!ok || log_q.size() != 33) begin
      n_bad++; $display("FAIL sparse_count: got %0d strobes (done=%0b) expected 33", log_q.size(), ok);
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_cmp++;
        if (log_q[2*i+1].bus !== {2'b01, exp_d[i]}) begin
          n_bad++; $display("FAIL sparse_R%0d: got %h expected %h", i, log_q[2*i+1].bus, {2'b01, exp_d[i]});
        end
      end
      n_cmp++;
      if (log_q[9].bus !== {2'b01, 8'h1E}) begin
        n_bad++; $display("FAIL sparse_R4: got %h expected 11e", log_q[9].bus);
      end
      bad_gap = 0;
      for (int k = 1; k < 33; k++) if (log_q[k].cyc - log_q[k-1].cyc != 4) bad_gap++;
      n_cmp++;
      if (bad_gap != 0) begin n_bad++; $display("FAIL sparse_spacing: got %0d bad gaps expected 0", bad_gap); end
    end
    n_cmp++;
    if (busy_cnt != 132) begin n_bad++; $display("FAIL sparse_busy: got %0d expected 132", busy_cnt); end
    clken_mode = 1;
  endtask

  task automatic test_shadow_restore();
    bit ok;
    CPU_RS = 1'b0; CPU_R_nW = 1'b0; CPU_DI = 8'h0E; CPU_REQ = 1'b1;
    wait_ack(10, ok);
    n_cmp++;
    if (!ok || {CRTC_ENABLE, CRTC_nCS, CRTC_R_nW, CRTC_RS, CRTC_DI} !== {4'b1000, 8'h0E}) begin
      n_bad++; $display("FAIL cpu_addr_wr: got ack=%0b %b/%h expected 1 1000/0e", ok,
                        {CRTC_ENABLE, CRTC_nCS, CRTC_R_nW, CRTC_RS}, CRTC_DI);
    end
    CPU_REQ = 1'b0;
    @(negedge CLOCK);
    clear_log();
    start_load(1'b0);
    wait_done(60, ok);
    repeat (2) @(negedge CLOCK);
    n_cmp++;
    if (!ok || log_q.size() != 33 || log_q[32].bus !== {2'b00, 8'h0E} || log_q[1].bus !== {2'b01, 8'h3F}) begin
      n_bad++; $display("FAIL restore_shadow: got n=%0d last=%h expected 33 last=00e", log_q.size(),
                        (log_q.size() > 0) ? log_q[log_q.size()-1].bus : 10'h3FF);
    end
    clear_log();
    CPU_RS = 1'b1; CPU_DI = 8'h55; CPU_REQ = 1'b1;
    wait_ack(10, ok);
    CPU_REQ = 1'b0;
    repeat (2) @(negedge CLOCK);
    n_cmp++;
    if (!ok || log_q.size() != 1 || log_q[0].bus !== {2'b01, 8'h55}) begin
      n_bad++; $display("FAIL cpu_data_wr: got n=%0d ack=%0b expected 1 strobe 155", log_q.size(), ok);
    end
  endtask

  task automatic test_cpu_vs_mode();
    bit ok;
    clear_log();
    CPU_RS = 1'b1; CPU_R_nW = 1'b0; CPU_DI = 8'h77; CPU_REQ = 1'b1;
    start_load(1'b0);
    wait_ack(80, ok);
    CPU_REQ = 1'b0;
    n_cmp++;
    if (!ok || done_cnt != 1 || ack_cyc != done_cyc + 2) begin
      n_bad++; $display("FAIL arb_ack_timing: got ack_cyc=%0d done_cyc=%0d done=%0d expected ack=done+2",
                        ack_cyc, done_cyc, done_cnt);
    end
    n_cmp++;
    if (log_q.size() != 34 || log_q[0].bus !== 10'h000 || log_q[33].bus !== {2'b01, 8'h77}) begin
      n_bad++; $display("FAIL arb_order: got n=%0d expected 34 with cpu write last", log_q.size());
    end
  endtask

  task automatic test_cpu_read();
    bit ok;
    clear_log();
    CRTC_DO = 8'hA5; CPU_RS = 1'b1; CPU_R_nW = 1'b1; CPU_DI = 8'h00; CPU_REQ = 1'b1;
    wait_ack(10, ok);
    n_cmp++;
    if (!ok || {CRTC_ENABLE, CRTC_nCS, CRTC_R_nW, CRTC_RS} !== 4'b1011) begin
      n_bad++; $display("FAIL rd_strobe: got ack=%0b %b expected 1 1011", ok,
                        {CRTC_ENABLE, CRTC_nCS, CRTC_R_nW, CRTC_RS});
    end
    CPU_REQ = 1'b0;
    @(negedge CLOCK);
    n_cmp++;
    if (CPU_DO !== 8'hA5 || CPU_ACK !== 1'b0) begin
      n_bad++; $display("FAIL rd_capture: got do=%h ack=%b expected a5 0", CPU_DO, CPU_ACK);
    end
    CRTC_DO = 8'h3C;
    CPU_R_nW = 1'b0; CPU_RS = 1'b1; CPU_DI = 8'h11; CPU_REQ = 1'b1;
    wait_ack(10, ok);
    CPU_REQ = 1'b0;
    repeat (3) @(negedge CLOCK);
    n_cmp++;
    if (CPU_DO !== 8'hA5 || ack_cnt != 2) begin
      n_bad++; $display("FAIL rd_hold: got do=%h acks=%0d expected a5 2", CPU_DO, ack_cnt);
    end
  endtask

  task automatic test_pending();
    bit ok1, ok2;
    int d1;
    clear_log();
    start_load(1'b0);
    repeat (5) @(negedge CLOCK);
    MODE_REQ = 1'b1;
    @(negedge CLOCK);
    MODE_REQ = 1'b0;
    wait_done(60, ok1);
    d1 = done_cyc;
    wait_done(60, ok2);
    repeat (6) @(negedge CLOCK);
    n_cmp++;
    if (!ok1 || !ok2 || done_cnt != 2 || log_q.size() != 66) begin
      n_bad++; $display("FAIL pend_loads: got done=%0d strobes=%0d expected 2 66", done_cnt, log_q.size());
    end else begin
      n_cmp++;
      if (log_q[33].cyc != d1 + 3 || log_q[33].bus !== 10'h000) begin
        n_bad++; $display("FAIL pend_restart: got cyc=%0d bus=%h expected cyc=%0d bus=000",
                          log_q[33].cyc, log_q[33].bus, d1 + 3);
      end
    end
  endtask

  task automatic test_reset_midload();
    bit ok;
    CPU_RS = 1'b0; CPU_R_nW = 1'b0; CPU_DI = 8'h0E; CPU_REQ = 1'b1;
    wait_ack(10, ok);
    CPU_REQ = 1'b0;
    @(negedge CLOCK);
    clear_log();
    start_load(1'b1);
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin @(negedge CLOCK); ok = (log_q.size() >= 10); end
    nRESET = 1'b0;
    #1;
    n_cmp++;
    if (!ok || {CRTC_ENABLE, CRTC_nCS, CRTC_R_nW, CRTC_RS, CRTC_DI, BUSY} !== {4'b0110, 8'h00, 1'b0}) begin
      n_bad++; $display("FAIL midreset_idle: got reached=%0b %b/%h busy=%b expected 1 0110/00 0", ok,
                        {CRTC_ENABLE, CRTC_nCS, CRTC_R_nW, CRTC_RS}, CRTC_DI, BUSY);
    end
    @(negedge CLOCK);
    clear_log();
    nRESET = 1'b1;
    wait_done(60, ok);
    repeat (2) @(negedge CLOCK);
    n_cmp++;
    if (!ok || log_q.size() != 33) begin
      n_bad++; $display("FAIL midreset_count: got %0d expected 33", log_q.size());
    end else begin
      n_cmp++;
      if (log_q[0].bus !== 10'h000 || log_q[1].bus !== {2'b01, 8'h3F} || log_q[32].bus !== 10'h000) begin
        n_bad++; $display("FAIL midreset_table0: got %h %h %h expected 000 13f 000",
                          log_q[0].bus, log_q[1].bus, log_q[32].bus);
      end
    end
  endtask

  initial begin
    test_reset();
    test_boot_load();
    test_mode1_sparse();
    test_shadow_restore();
    test_cpu_vs_mode();
    test_cpu_read();
    test_pending();
    test_reset_midload();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
